fsk_demod: RTL and testbench

Non-coherent 2FSK demodulator, the receive-side counterpart of the DDS-based FSK modulator. Consumes the 14-bit signed sample stream at the sampling clock and classifies each symbol window by counting zero crossings, with hysteresis. Emits one recovered serial bit per window, plus a carrier-presence flag and a crossing-count debug value. Sits between the ADC/loopback sample path and the UART receiver.

---
 rtl/fsk_demod.sv | 183 ++++++++++++++++++
 tb/tb_fsk_demod.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_demod.sv
// ---------------------------------------------------------------------------
// fsk_demod -- non-coherent 2FSK demodulator (zero-crossing counter).
//
// Each symbol window of SAMPLES_PER_BIT valid samples is classified by the
// number of hysteretic sign changes it contains: a low crossing count is the
// low tone (bit 1), a high count is the high tone (bit 0). The window peak
// magnitude is compared against AMP_MIN to report carrier presence.
//
// Pipeline:
//   stage 1 : sample/valid register
//   stage 2 : hysteretic sign, crossing counter, peak, window counter;
//             latches the final window values when the window completes
//   output  : decision registers, one-cycle data_valid
//
// Ports:
//   clk_sample     in   1  sampling clock, rising edge
//   rst            in   1  asynchronous reset, active-high
//   data_in        in  14  signed two's-complement sample
//   data_in_valid  in   1  sample qualifier
//   sym_sync       in   1  restart the symbol window (pulse)
//   data_out       out  1  recovered bit, held until next decision
//   data_valid     out  1  one-cycle pulse per decision
//   carrier_ok     out  1  window peak >= AMP_MIN, updated per decision
//   xcnt_out       out  W  crossing count of last window
// ---------------------------------------------------------------------------
module fsk_demod #(
  parameter int SAMPLES_PER_BIT = 64,
  parameter int XCNT_THRESHOLD  = 40,
  parameter int HYST            = 256,
  parameter int AMP_MIN         = 512,
  localparam int W              = $clog2(SAMPLES_PER_BIT + 1)
) (
  input  logic                clk_sample,
  input  logic                rst,
  input  logic signed [13:0]  data_in,
  input  logic                data_in_valid,
  input  logic                sym_sync,
  output logic                data_out,
  output logic                data_valid,
  output logic                carrier_ok,
  output logic [W-1:0]        xcnt_out
);

  localparam logic [W-1:0]        L_SPB      = W'(SAMPLES_PER_BIT);
  localparam logic [W-1:0]        L_THRESH   = W'(XCNT_THRESHOLD);
  localparam logic signed [13:0]  L_HYST_POS = 14'(HYST);
  localparam logic signed [13:0]  L_HYST_NEG = 14'(-HYST);
  localparam logic [13:0]         L_AMP_MIN  = 14'(AMP_MIN);

  // Stage 1
  logic signed [13:0] r_s1_data;
  logic               r_s1_valid;

  // Stage 2 window state
  logic               r_neg;        // hysteretic sign, 1 = negative
  logic [W-1:0]       r_wcnt;       // valid samples seen in this window
  logic [W-1:0]       r_xcnt;       // sign changes seen in this window
  logic [13:0]        r_peak;       // max |sample| in this window

  // Completed-window values handed to the output stage
  logic               r_done;
  logic [W-1:0]       r_fin_xcnt;
  logic               r_fin_car;

  // Stage 2 next-state values
  logic               w_neg_next;
  logic [W-1:0]       w_xcnt_next;
  logic [13:0]        w_abs;
  logic [13:0]        w_peak_next;
  logic [W-1:0]       w_wcnt_next;
  logic               w_last;

  // -------------------------------------------------------------------------
  // Stage 1: register the sample and its qualifier. A sample arriving with
  // sym_sync is simply captured here; it becomes sample 1 of the new window.
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= data_in_valid;
      if (data_in_valid) begin
        r_s1_data <= data_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 combinational update for the registered sample.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_neg_next  = r_neg;
    w_xcnt_next = r_xcnt;
    w_abs       = r_s1_data[13] ? 14'(-r_s1_data) : 14'(r_s1_data);
    w_peak_next = r_peak;
    w_wcnt_next = r_wcnt + 1'b1;
    w_last      = 1'b0;

    // Samples inside the +/-HYST deadband keep the previous sign.
    if (r_s1_data > L_HYST_POS) begin
      w_neg_next = 1'b0;
    end else if (r_s1_data < L_HYST_NEG) begin
      w_neg_next = 1'b1;
    end

    // Saturate at one window's worth so the count can never wrap.
    if ((w_neg_next != r_neg) && (r_xcnt != L_SPB)) begin
      w_xcnt_next = r_xcnt + 1'b1;
    end

    // |-8192| = 8192 fits the 14-bit unsigned magnitude.
    if (w_abs > r_peak) begin
      w_peak_next = w_abs;
    end

    w_last = (w_wcnt_next == L_SPB);
  end

  // -------------------------------------------------------------------------
  // Stage 2 registers. sym_sync drops the in-flight stage-1 sample and the
  // partial window, but keeps the sign so the next window's first crossing
  // is judged against the true line state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      r_neg      <= 1'b0;
      r_wcnt     <= '0;
      r_xcnt     <= '0;
      r_peak     <= '0;
      r_done     <= 1'b0;
      r_fin_xcnt <= '0;
      r_fin_car  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sym_sync) begin
        r_wcnt <= '0;
        r_xcnt <= '0;
        r_peak <= '0;
      end else if (r_s1_valid) begin
        r_neg <= w_neg_next;
        if (w_last) begin
          // Final values include this sample's crossing and peak.
          r_done     <= 1'b1;
          r_fin_xcnt <= w_xcnt_next;
          r_fin_car  <= (w_peak_next >= L_AMP_MIN);
          r_wcnt     <= '0;
          r_xcnt     <= '0;
          r_peak     <= '0;
        end else begin
          r_wcnt <= w_wcnt_next;
          r_xcnt <= w_xcnt_next;
          r_peak <= w_peak_next;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage. Runs off r_done only, so a decision pending on the same
  // edge as sym_sync is still emitted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      carrier_ok <= 1'b0;
      xcnt_out   <= '0;
    end else begin
      data_valid <= r_done;
      if (r_done) begin
        data_out   <= (r_fin_xcnt < L_THRESH);
        xcnt_out   <= r_fin_xcnt;
        carrier_ok <= r_fin_car;
      end
    end
  end

endmodule

// File: tb/tb_fsk_demod.sv
// ---------------------------------------------------------------------------
// tb_fsk_demod -- directed bench for fsk_demod with default parameters
// (64 samples/bit, threshold 40, HYST 256, AMP_MIN 512).
// Table vectors run one reset-framed window each; hand-written sequences
// cover back-to-back windows, valid gaps, sym_sync and mid-window reset.
// ---------------------------------------------------------------------------
module tb_fsk_demod;

  localparam int W = 7;

  logic              clk_sample;
  logic              rst;
  logic signed [13:0] data_in;
  logic              data_in_valid;
  logic              sym_sync;
  logic              data_out;
  logic              data_valid;
  logic              carrier_ok;
  logic [W-1:0]      xcnt_out;

  fsk_demod dut (
    .clk_sample    (clk_sample),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .sym_sync      (sym_sync),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .carrier_ok    (carrier_ok),
    .xcnt_out      (xcnt_out)
  );

  initial clk_sample = 1'b0;
  always #5 clk_sample = ~clk_sample;

  int cyc = 0;
  always @(posedge clk_sample) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  int ph       = 0;   // DDS phase, 16-bit
  int last_acc = 0;   // edge number that accepted the latest valid sample
  int sync_acc = 0;   // edge number that carried the latest sym_sync

  // Decisions seen on data_valid, sampled on the falling edge.
  typedef struct {
    int cyc;
    int d;
    int x;
    int c;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk_sample) begin
    if (data_valid) begin
      ev_t e;
      e.cyc = cyc;
      e.d   = int'(data_out);
      e.x   = int'(xcnt_out);
      e.c   = int'(carrier_ok);
      evq.push_back(e);
    end
  end

  // kind 0: sine, arg = phase increment
  // kind 1: alternate -amp/+amp for the first arg samples, then hold
  typedef struct {
    int kind;
    int arg;
    int amp;
    int exp_x;
    int exp_bit;
    int exp_car;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_total++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int sine_val(input int phase, input int amp);
    real r;
    r = amp * $sin(6.283185307179586 * phase / 65536.0);
    return $rtoi(r);
  endfunction

  function automatic int alt_val(input int k, input int nchg, input int amp);
    int kk;
    kk = (k <= nchg) ? k : nchg;
    if (kk == 0) return 0;
    return (kk % 2 == 1) ? -amp : amp;
  endfunction

  task automatic send(input int val, input bit v, input bit s);
    @(negedge clk_sample);
    data_in       = 14'(val);
    data_in_valid = v;
    sym_sync      = s;
    if (v) last_acc = cyc + 1;
    if (s) sync_acc = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk_sample);
    data_in_valid = 1'b0;
    sym_sync      = 1'b0;
  endtask

  task automatic send_sine(input int incr, input int amp, input int n);
    for (int i = 0; i < n; i++) begin
      send(sine_val(ph, amp), 1'b1, 1'b0);
      ph = (ph + incr) % 65536;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sample);
    rst           = 1'b1;
    data_in_valid = 1'b0;
    sym_sync      = 1'b0;
    data_in       = '0;
    repeat (2) @(negedge clk_sample);
    rst = 1'b0;
    evq.delete();
    ph = 0;
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      @(posedge clk_sample);
      k++;
    end
    if (evq.size() < n) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d pulses expected %0d", name, evq.size(), n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int acc0;
    int bits[4];

    vecs[0] = '{0, 18432, 8000, 35, 1, 1};  // 18 MHz tone
    vecs[1] = '{0, 22528, 8000, 43, 0, 1};  // 22 MHz tone
    vecs[2] = '{0, 18432,  100,  0, 1, 0};  // weak tone, inside deadband
    vecs[3] = '{1,    64,  300, 64, 0, 0};  // maximum crossings
    vecs[4] = '{1,    40,  300, 40, 0, 0};  // count == threshold
    vecs[5] = '{1,    39,  300, 39, 1, 0};  // count == threshold-1
    vecs[6] = '{1,    64,  256,  0, 1, 0};  // exactly +/-HYST: no change
    vecs[7] = '{1,    10,  257, 10, 1, 0};  // just outside deadband
    vecs[8] = '{1,     1,  512,  1, 1, 1};  // peak |-512| == AMP_MIN
    vecs[9] = '{1,     2,  511,  2, 1, 0};  // peak one below AMP_MIN

    rst           = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    sym_sync      = 1'b0;
    repeat (2) @(negedge clk_sample);
    check("reset data_out",   int'(data_out),   0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset carrier_ok", int'(carrier_ok), 0);
    check("reset xcnt_out",   int'(xcnt_out),   0);
    rst = 1'b0;
    @(negedge clk_sample);
    check("post-reset data_valid", int'(data_valid), 0);

    // ---- table-driven single windows ----
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int k = 1; k <= 64; k++) begin
        if (vecs[v].kind == 0) begin
          send(sine_val(ph, vecs[v].amp), 1'b1, 1'b0);
          ph = (ph + vecs[v].arg) % 65536;
        end else begin
          send(alt_val(k, vecs[v].arg, vecs[v].amp), 1'b1, 1'b0);
        end
      end
      idle();
      wait_pulses($sformatf("vec%0d pulse", v), 1, 20);
      repeat (5) @(posedge clk_sample);
      check($sformatf("vec%0d pulse count", v), evq.size(), 1);
      if (evq.size() > 0) begin
        check($sformatf("vec%0d latency", v),    evq[0].cyc - last_acc, 2);
        check($sformatf("vec%0d xcnt_out", v),   evq[0].x, vecs[v].exp_x);
        check($sformatf("vec%0d data_out", v),   evq[0].d, vecs[v].exp_bit);
        check($sformatf("vec%0d carrier_ok", v), evq[0].c, vecs[v].exp_car);
      end
    end

    // ---- back-to-back windows, bits 1,0,1,1, continuous phase ----
    do_reset();
    bits = '{1, 0, 1, 1};
    acc0 = 0;
    for (int b = 0; b < 4; b++) begin
      send_sine(bits[b] == 1 ? 18432 : 22528, 8000, 64);
      if (b == 0) acc0 = last_acc;
    end
    idle();
    wait_pulses("seq pulses", 4, 20);
    repeat (5) @(posedge clk_sample);
    check("seq pulse count", evq.size(), 4);
    if (evq.size() >= 4) begin
      check("seq first latency", evq[0].cyc - acc0, 2);
      for (int b = 0; b < 4; b++) begin
        check($sformatf("seq bit%0d data_out", b), evq[b].d, bits[b]);
        if (bits[b] == 1)
          check_range($sformatf("seq bit%0d xcnt", b), evq[b].x, 35, 37);
        else
          check_range($sformatf("seq bit%0d xcnt", b), evq[b].x, 43, 45);
        if (b > 0)
          check($sformatf("seq spacing%0d", b), evq[b].cyc - evq[b-1].cyc, 64);
      end
    end

    // ---- valid toggling 1/0: gaps must not count ----
    do_reset();
    for (int k = 0; k < 64; k++) begin
      send(sine_val(ph, 8000), 1'b1, 1'b0);
      ph = (ph + 18432) % 65536;
      send(-5000, 1'b0, 1'b0);
    end
    idle();
    wait_pulses("gap pulse", 1, 20);
    repeat (5) @(posedge clk_sample);
    check("gap pulse count", evq.size(), 1);
    if (evq.size() > 0) begin
      check("gap latency",    evq[0].cyc - last_acc, 2);
      check("gap xcnt_out",   evq[0].x, 35);
      check("gap data_out",   evq[0].d, 1);
      check("gap carrier_ok", evq[0].c, 1);
    end

    // ---- sym_sync at sample 30 aborts the window ----
    do_reset();
    send_sine(22528, 8000, 64);
    idle();
    wait_pulses("sync first pulse", 1, 20);
    send_sine(18432, 8000, 29);
    send(sine_val(ph, 8000), 1'b1, 1'b1);
    ph = (ph + 18432) % 65536;
    send_sine(18432, 8000, 10);
    check("sync hold data_out",   int'(data_out),   0);
    check("sync hold xcnt_out",   int'(xcnt_out),   43);
    check("sync hold carrier_ok", int'(carrier_ok), 1);
    send_sine(18432, 8000, 53);
    check("sync no aborted pulse", evq.size(), 1);
    idle();
    wait_pulses("sync second pulse", 2, 20);
    repeat (5) @(posedge clk_sample);
    check("sync pulse count", evq.size(), 2);
    if (evq.size() >= 2) begin
      check("sync pulse timing", evq[1].cyc - sync_acc, 65);
      check("sync data_out", evq[1].d, 1);
      check_range("sync xcnt_out", evq[1].x, 35, 37);
    end

    // ---- sym_sync on the same edge as a decision ----
    do_reset();
    send_sine(22528, 8000, 64);
    p = last_acc;
    send_sine(18432, 8000, 1);
    send(sine_val(ph, 8000), 1'b1, 1'b1);
    ph = (ph + 18432) % 65536;
    send_sine(18432, 8000, 63);
    idle();
    wait_pulses("coinc pulses", 2, 20);
    repeat (5) @(posedge clk_sample);
    check("coinc pulse count", evq.size(), 2);
    if (evq.size() >= 2) begin
      check("coinc first timing",  evq[0].cyc - p, 2);
      check("coinc first data",    evq[0].d, 0);
      check("coinc second timing", evq[1].cyc - p, 67);
      check("coinc second data",   evq[1].d, 1);
    end

    // ---- reset at sample 50 of a window ----
    do_reset();
    send_sine(22528, 8000, 64);
    idle();
    wait_pulses("rst setup pulse", 1, 20);
    send_sine(18432, 8000, 50);
    @(negedge clk_sample);
    #2 rst = 1'b1;
    #1;
    check("rst async carrier_ok", int'(carrier_ok), 0);
    check("rst async xcnt_out",   int'(xcnt_out),   0);
    check("rst async data_out",   int'(data_out),   0);
    check("rst async data_valid", int'(data_valid), 0);
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk_sample);
    rst = 1'b0;
    evq.delete();
    ph = 0;
    @(negedge clk_sample);
    check("rst release xcnt_out", int'(xcnt_out), 0);
    send_sine(18432, 8000, 63);
    check("rst no early pulse",    evq.size(), 0);
    check("rst hold carrier_ok",   int'(carrier_ok), 0);
    send_sine(18432, 8000, 1);
    idle();
    wait_pulses("rst pulse", 1, 20);
    repeat (5) @(posedge clk_sample);
    check("rst pulse count", evq.size(), 1);
    if (evq.size() > 0) begin
      check("rst latency",    evq[0].cyc - last_acc, 2);
      check("rst xcnt_out",   evq[0].x, 35);
      check("rst data_out",   evq[0].d, 1);
      check("rst carrier_ok", evq[0].c, 1);
    end

    repeat (3) @(negedge clk_sample);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
